insertion_sort: RTL and testbench

//  Sequential insertion sorter for a fixed-size array of unsigned words, ascending order.

---
 rtl/insertion_sort.sv | 73 +++++++
 tb/tb_insertion_sort.sv | 135 +++++++++++++
 2 files changed

// File: rtl/insertion_sort.sv
// insertion_sort: sequential stable ascending insertion sorter, one compare-and-shift step per cycle
module insertion_sort #(
  parameter int NUM_VALS  = 8,
  parameter int SIZE_DATA = 8
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_start,
  input  logic [SIZE_DATA-1:0] i_data [NUM_VALS],
  output logic                 o_done,
  output logic [SIZE_DATA-1:0] o_data [NUM_VALS]
);
  localparam int AW = $clog2(NUM_VALS);
  localparam int IW = AW + 1;
  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;
  state_t               state;
  logic [SIZE_DATA-1:0] arr     [NUM_VALS];
  logic [SIZE_DATA-1:0] arr_ins [NUM_VALS];
  logic [SIZE_DATA-1:0] key;
  logic [IW-1:0]        i, p, pm1;
  logic                 shift_en, last;
  always_comb begin
    pm1      = p - IW'(1);
    shift_en = (p != '0) && (arr[pm1[AW-1:0]] > key);
    last     = (i == IW'(NUM_VALS - 1));
    arr_ins  = arr;
    arr_ins[p[AW-1:0]] = key;
  end
  // equal keys stop the shift, which keeps the sort stable
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state  <= IDLE;
      o_done <= 1'b0;
      o_data <= '{default: '0};
      arr    <= '{default: '0};
      key    <= '0;
      i      <= '0;
      p      <= '0;
    end else begin
      case (state)
        IDLE: if (i_start) begin
          arr   <= i_data;
          i     <= IW'(1);
          state <= FETCH;
        end
        FETCH: begin
          key   <= arr[i[AW-1:0]];
          p     <= i;
          state <= SHIFT;
        end
        SHIFT: if (shift_en) begin
          arr[p[AW-1:0]] <= arr[pm1[AW-1:0]];
          p              <= pm1;
        end else begin
          arr <= arr_ins;
          if (last) begin
            o_data <= arr_ins;
            o_done <= 1'b1;
            state  <= DONE;
          end else begin
            i     <= i + IW'(1);
            state <= FETCH;
          end
        end
        DONE: if (!i_start) begin
          o_done <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_insertion_sort.sv
// tb_insertion_sort: table-driven and randomized checks of insertion_sort against a queue-sort model
module tb_insertion_sort;
  localparam int N = 8;
  localparam int W = 8;
  typedef logic [N-1:0][W-1:0] vec_t;
  typedef struct {
    vec_t  din;
    vec_t  exp;
    int    lat;
    string name;
  } rec_t;
  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] din  [N];
  logic         done;
  logic [W-1:0] dout [N];
  int checks = 0;
  int errors = 0;
  insertion_sort #(.NUM_VALS(N), .SIZE_DATA(W)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_data(din),
    .o_done(done), .o_data(dout)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(input int a0, a1, a2, a3, a4, a5, a6, a7);
    vec_t v;
    v[0] = W'(a0); v[1] = W'(a1); v[2] = W'(a2); v[3] = W'(a3);
    v[4] = W'(a4); v[5] = W'(a5); v[6] = W'(a6); v[7] = W'(a7);
    return v;
  endfunction
  function automatic vec_t model_sort(input vec_t v);
    int   q[$];
    vec_t r;
    for (int k = 0; k < N; k++) q.push_back(int'(v[k]));
    q.sort();
    for (int k = 0; k < N; k++) r[k] = W'(q[k]);
    return r;
  endfunction
  function automatic int model_lat(input vec_t v);
    int inv = 0;
    for (int a = 0; a < N; a++)
      for (int b = a + 1; b < N; b++)
        if (v[a] > v[b]) inv++;
    return 1 + 2 * (N - 1) + inv;
  endfunction
  function automatic vec_t dout_vec();
    vec_t r;
    for (int k = 0; k < N; k++) r[k] = dout[k];
    return r;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic chk_arr(input string name, input vec_t exp);
    vec_t act = dout_vec();
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  // start a sort, count edges to o_done, check result, hold, then release
  task automatic sort_run(input vec_t v, input vec_t exp, input int lat, input string name, input bit scramble);
    int edges = 0;
    bit got = 0;
    @(negedge clk);
    for (int k = 0; k < N; k++) din[k] = v[k];
    start = 1'b1;
    while (!got && edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (scramble && edges == 4) for (int k = 0; k < N; k++) din[k] = W'($urandom);
      if (done) got = 1;
    end
    chk({name, " latency"}, 64'(edges), 64'(lat));
    chk_arr({name, " data"}, exp);
    repeat (3) @(posedge clk);
    #1 chk({name, " done held"}, 64'(done), 64'd1);
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;
    chk({name, " done fell"}, 64'(done), 64'd0);
    chk_arr({name, " retained"}, exp);
  endtask
  initial begin
    rec_t tbl[$];
    vec_t v;
    for (int k = 0; k < N; k++) din[k] = '0;
    tbl.push_back('{mk(12,1,1,20,0,15,29,1), mk(0,1,1,1,12,15,20,29), 26, "mixed"});
    tbl.push_back('{mk(0,1,2,3,4,5,6,7), mk(0,1,2,3,4,5,6,7), 15, "sorted"});
    tbl.push_back('{mk(7,6,5,4,3,2,1,0), mk(0,1,2,3,4,5,6,7), 43, "reverse"});
    tbl.push_back('{mk(255,255,255,255,255,255,255,255), mk(255,255,255,255,255,255,255,255), 15, "equal"});
    tbl.push_back('{mk(255,0,255,0,255,0,255,0), mk(0,0,0,0,255,255,255,255), 25, "extremes"});
    repeat (2) @(posedge clk);
    #1;
    chk("reset done", 64'(done), 64'd0);
    chk_arr("reset data", '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1 chk("idle no start", 64'(done), 64'd0);
    for (int t = 0; t < tbl.size(); t++)
      sort_run(tbl[t].din, tbl[t].exp, tbl[t].lat, tbl[t].name, 1'b0);
    v = mk(9,3,200,3,77,0,128,5);
    sort_run(v, model_sort(v), model_lat(v), "scrambled inputs", 1'b1);
    // abort a reverse sort while it is shifting
    @(negedge clk);
    v = mk(7,6,5,4,3,2,1,0);
    for (int k = 0; k < N; k++) din[k] = v[k];
    start = 1'b1;
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b0;
    start = 1'b0;
    @(posedge clk); #1;
    chk("abort done", 64'(done), 64'd0);
    chk_arr("abort data", '0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 chk("abort idle", 64'(done), 64'd0);
    v = mk(40,30,20,10,40,30,20,10);
    sort_run(v, model_sort(v), model_lat(v), "after abort", 1'b0);
    for (int r = 0; r < 20; r++) begin
      for (int k = 0; k < N; k++) v[k] = (r % 2) ? W'($urandom_range(0, 5)) : W'($urandom);
      sort_run(v, model_sort(v), model_lat(v), $sformatf("random%0d", r), 1'b0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
